// File: rtl/ahfp_floor_arbiter.sv
// Round-robin arbiter feeding one shared combinational floor unit through a short
// result pipeline; each result is returned tagged with the requester that issued it.
module ahfp_floor_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             fp_data,
    input  logic [31:0]             fp_result,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_data,
    input  logic                    rsp_ready,
    output logic [ID_W+1:0]         inflight
);

    logic            st_valid [LATENCY];
    logic [ID_W-1:0] st_id    [LATENCY];
    logic [31:0]     st_data  [LATENCY];

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            advance;
    int              idx;

    assign advance = !st_valid[LATENCY-1] || rsp_ready;

    // Scan requesters starting at ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!reset && found && advance) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign ptr_nxt = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;

    // The whole pipe moves together; a stalled last stage freezes every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_valid[i] <= 1'b0;
                st_id[i]    <= '0;
                st_data[i]  <= '0;
            end
        end else if (advance) begin
            st_valid[0] <= found;
            if (found) begin
                st_id[0]   <= winner;
                st_data[0] <= req_data[32*int'(winner) +: 32];
                ptr        <= ptr_nxt;
            end
            st_valid[1] <= st_valid[0];
            st_id[1]    <= st_id[0];
            st_data[1]  <= fp_result;
            for (int i = 2; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_id[i]    <= st_id[i-1];
                st_data[i]  <= st_data[i-1];
            end
        end
    end

    assign fp_data   = st_data[0];
    assign rsp_valid = st_valid[LATENCY-1];
    assign rsp_id    = st_id[LATENCY-1];
    assign rsp_data  = st_data[LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            if (st_valid[i]) begin
                inflight = inflight + (ID_W+2)'(1);
            end
        end
    end

endmodule

// File: tb/tb_ahfp_floor_arbiter.sv
// Bench for ahfp_floor_arbiter: directed sequences, an arbitration vector table and a
// randomized run, all scored against a queue of expected responses in accept order.
module tb_ahfp_floor_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int LATENCY = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [31:0]           fp_data;
    logic [31:0]           fp_result;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_ready;
    logic [ID_W+1:0]       inflight;

    ahfp_floor_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fp_data   (fp_data),
        .fp_result (fp_result),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference single-precision floor; also serves as the shared floor unit.
    function automatic logic [31:0] floor_f(input logic [31:0] x);
        int e;
        logic [31:0] mask;
        e = int'(x[30:23]) - 127;
        if (x[30:23] == 8'hFF || e >= 23) return x;
        if (e < 0) begin
            if (x[30:0] == 31'd0) return x;
            return x[31] ? 32'hBF800000 : 32'h00000000;
        end
        mask = (32'h1 << (23 - e)) - 32'h1;
        if ((x & mask) == 32'h0) return x;
        if (!x[31]) return x & ~mask;
        return (x & ~mask) + (32'h1 << (23 - e));
    endfunction

    always_comb fp_result = floor_f(fp_data);

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     d;
    } exp_t;

    exp_t               sb_q[$];
    int                 waitc [NUM_REQ];
    logic [NUM_REQ-1:0] acc_last = '0;

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        exp_t e;
        acc_last = req_valid & req_ready;
        if (reset) begin
            sb_q.delete();
            for (int i = 0; i < NUM_REQ; i++) waitc[i] = 0;
        end else begin
            chk("inflight", 32'(inflight), 32'(sb_q.size()));
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", rsp_data, e.d);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = ID_W'(i);
                    e.d  = floor_f(req_data[32*i +: 32]);
                    sb_q.push_back(e);
                    chk("fairness", 32'(waitc[i] <= NUM_REQ - 1), 32'd1);
                    waitc[i] = 0;
                end else if (!req_valid[i]) begin
                    waitc[i] = 0;
                end else if (|(req_valid & req_ready)) begin
                    waitc[i]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r = {r[31], 8'(120 + $urandom_range(0, 30)), r[22:0]};
            1: r = {r[31], 8'(127 + $urandom_range(0, 10)), r[22:12], 12'h000};
            default: ;
        endcase
        return r;
    endfunction

    typedef struct {
        logic [NUM_REQ-1:0] rv;
        logic [NUM_REQ-1:0] rr;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] t2_in  [NUM_REQ];
    logic [31:0] t2_exp [5];
    logic [ID_W-1:0] s_id;
    logic [31:0]     s_data;

    initial begin
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100};
        tbl[2]  = '{4'b0110, 4'b0010};
        tbl[3]  = '{4'b0110, 4'b0100};
        tbl[4]  = '{4'b1001, 4'b1000};
        tbl[5]  = '{4'b1001, 4'b0001};
        tbl[6]  = '{4'b1111, 4'b0010};
        tbl[7]  = '{4'b1011, 4'b1000};
        tbl[8]  = '{4'b0000, 4'b0000};
        tbl[9]  = '{4'b1010, 4'b0010};
        tbl[10] = '{4'b0001, 4'b0001};
        tbl[11] = '{4'b0001, 4'b0001};
        t2_in  = '{32'h41EC0000, 32'h42FF999A, 32'h3F0F5C29, 32'h3F800000};
        t2_exp = '{32'h41E80000, 32'h42FE0000, 32'h00000000, 32'h3F800000, 32'h41E80000};

        // Reset state, with requests asserted to confirm no grant during reset.
        reset     = 1'b1;
        req_valid = '1;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_fp_data", fp_data, 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;

        // Single request, two-cycle latency.
        req_valid          = 4'b0001;
        req_data[31:0]     = 32'h4015FC65;
        @(negedge clk);
        chk("t1_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t1_early", 32'(rsp_valid), 32'd0);
        chk("t1_fp_data", fp_data, 32'h4015FC65);
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_id", 32'(rsp_id), 32'd0);
        chk("t1_data", rsp_data, 32'h40000000);
        step();

        // All requesters valid: rotation 0,1,2,3,0 at one result per cycle.
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                req_valid = '1;
                for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = t2_in[i];
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (c < 5) chk("t2_grant", 32'(req_ready), 32'h1 << (c % NUM_REQ));
            if (c >= 2) begin
                chk("t2_valid", 32'(rsp_valid), 32'd1);
                chk("t2_id", 32'(rsp_id), 32'((c - 2) % NUM_REQ));
                chk("t2_data", rsp_data, t2_exp[c-2]);
            end
            step();
        end

        // Downstream stall with a full pipe, then drain.
        req_valid = '1;
        for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = rnd_op();
        repeat (3) step();
        rsp_ready = 1'b0;
        @(negedge clk);
        s_id   = rsp_id;
        s_data = rsp_data;
        chk("t3_valid", 32'(rsp_valid), 32'd1);
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_ready", 32'(req_ready), 32'd0);
            chk("t3_inflight", 32'(inflight), 32'(LATENCY));
            chk("t3_hold_v", 32'(rsp_valid), 32'd1);
            chk("t3_hold_id", 32'(rsp_id), 32'(s_id));
            chk("t3_hold_d", rsp_data, s_data);
            step();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (4) step();
        @(negedge clk);
        chk("t3_drained", 32'(inflight), 32'd0);
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);
        step();

        // Arbitration vector table from a fresh pointer.
        apply_reset();
        foreach (tbl[v]) begin
            req_valid = tbl[v].rv;
            for (int i = 0; i < NUM_REQ; i++) req_data[32*i +: 32] = rnd_op();
            @(negedge clk);
            chk($sformatf("tbl%0d_grant", v), 32'(req_ready), 32'(tbl[v].rr));
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Reset with two operations in flight.
        req_valid      = 4'b0001;
        req_data[31:0] = 32'h3FC00000;
        step();
        req_valid       = 4'b0010;
        req_data[63:32] = 32'hC0500000;
        step();
        reset     = 1'b1;
        req_valid = '1;
        @(negedge clk);
        chk("t5_ready_in_rst", 32'(req_ready), 32'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_inflight", 32'(inflight), 32'd0);
        chk("t5_ptr0_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        repeat (4) step();

        // Randomized traffic; requests stay asserted until granted.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req_valid[i] && !acc_last[i])) begin
                    req_valid[i]         = ($urandom_range(0, 2) != 0);
                    req_data[32*i +: 32] = rnd_op();
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && inflight != 0; k++) step();
        @(negedge clk);
        chk("final_inflight", 32'(inflight), 32'd0);
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
